// File: rtl/pll_lock_sequencer_if.sv
// Status and control bundle between the PLL lock sequencer and its surroundings.
// The master side is the sequencer. It samples the PLL lock flag and the restart request,
// and it drives the PLL reset, the system reset and the status flags.
interface pll_lock_sequencer_if #(
    parameter int RETRY_W = 2
);
    logic               locked;
    logic               restart;
    logic               pll_rst;
    logic               sys_rst;
    logic               ready;
    logic               fail;
    logic [RETRY_W-1:0] retry_count;
    logic               lock_lost;

    modport master (
        input  locked,
        input  restart,
        output pll_rst,
        output sys_rst,
        output ready,
        output fail,
        output retry_count,
        output lock_lost
    );

    modport slave (
        output locked,
        output restart,
        input  pll_rst,
        input  sys_rst,
        input  ready,
        input  fail,
        input  retry_count,
        input  lock_lost
    );
endinterface

// File: rtl/pll_lock_sequencer.sv
// Power-up and recovery sequencer for the refclk-referenced core PLL.
// The sequencer pulses the PLL reset and qualifies a synchronised lock flag over a
// stability window. It releases the system reset only in RUN. A lock loss or a timeout
// sends it back through the reset pulse. Once the retries are used up it parks in FAIL
// until a restart request or rst arrives. Every output is a flop that is loaded from the
// next-state decode, so there is no combinational path from an input to an output.
module pll_lock_sequencer #(
    parameter int PLL_RST_CYCLES      = 16,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT_CYCLES = 65536,
    parameter int MAX_RETRIES         = 3,
    parameter int CNT_W               = 17,
    parameter int RETRY_W             = 2
) (
    input  logic                 refclk,
    input  logic                 rst,
    pll_lock_sequencer_if.master bus
);

    typedef enum logic [2:0] {
        S_RESET     = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABLE    = 3'd2,
        S_RUN       = 3'd3,
        S_FAIL      = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0]   RST_LAST    = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]   STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TMO_LAST    = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0]   CNT_ONE     = CNT_W'(1);
    localparam logic [RETRY_W-1:0] RETRY_MAX   = RETRY_W'(MAX_RETRIES);
    localparam logic [RETRY_W-1:0] RETRY_ONE   = RETRY_W'(1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   tmo_q, tmo_d;
    logic [RETRY_W-1:0] retry_q, retry_d;
    logic               lock_lost_q, lock_lost_d;

    logic               meta_q;
    logic               locked_sync_q;

    logic               pll_rst_q;
    logic               sys_rst_q;
    logic               ready_q;
    logic               fail_q;

    // Two-flop synchroniser for the asynchronous PLL lock flag.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            meta_q        <= 1'b0;
            locked_sync_q <= 1'b0;
        end else begin
            meta_q        <= bus.locked;
            locked_sync_q <= meta_q;
        end
    end

    // Next-state logic: restart wins over everything, and the timeout is tested before the lock tests.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        tmo_d       = tmo_q;
        retry_d     = retry_q;
        lock_lost_d = lock_lost_q;

        if (bus.restart) begin
            state_d     = S_RESET;
            cnt_d       = '0;
            tmo_d       = '0;
            retry_d     = '0;
            lock_lost_d = 1'b0;
        end else begin
            case (state_q)
                S_RESET: begin
                    if (cnt_q == RST_LAST) begin
                        state_d = S_WAIT_LOCK;
                        cnt_d   = '0;
                        tmo_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end

                S_WAIT_LOCK, S_STABLE: begin
                    tmo_d = tmo_q + CNT_ONE;
                    if (tmo_q == TMO_LAST) begin
                        tmo_d = '0;
                        if (retry_q < RETRY_MAX) begin
                            retry_d = retry_q + RETRY_ONE;
                            state_d = S_RESET;
                            cnt_d   = '0;
                        end else begin
                            state_d = S_FAIL;
                        end
                    end else if (state_q == S_WAIT_LOCK) begin
                        if (locked_sync_q) begin
                            state_d = S_STABLE;
                            cnt_d   = '0;
                        end
                    end else if (!locked_sync_q) begin
                        // Lock chatter: the timeout keeps running, so a flapping PLL still times out.
                        state_d = S_WAIT_LOCK;
                    end else if (cnt_q == STABLE_LAST) begin
                        state_d = S_RUN;
                        retry_d = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end

                S_RUN: begin
                    if (!locked_sync_q) begin
                        state_d     = S_RESET;
                        cnt_d       = '0;
                        lock_lost_d = 1'b1;
                    end
                end

                S_FAIL: begin
                    state_d = S_FAIL;
                end

                default: begin
                    state_d = S_RESET;
                    cnt_d   = '0;
                    tmo_d   = '0;
                end
            endcase
        end
    end

    // State, counters and output flops; outputs decode the next state so they change with it.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state_q     <= S_RESET;
            cnt_q       <= '0;
            tmo_q       <= '0;
            retry_q     <= '0;
            lock_lost_q <= 1'b0;
            pll_rst_q   <= 1'b1;
            sys_rst_q   <= 1'b1;
            ready_q     <= 1'b0;
            fail_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            tmo_q       <= tmo_d;
            retry_q     <= retry_d;
            lock_lost_q <= lock_lost_d;
            pll_rst_q   <= (state_d == S_RESET) || (state_d == S_FAIL);
            sys_rst_q   <= (state_d != S_RUN);
            ready_q     <= (state_d == S_RUN);
            fail_q      <= (state_d == S_FAIL);
        end
    end

    assign bus.pll_rst     = pll_rst_q;
    assign bus.sys_rst     = sys_rst_q;
    assign bus.ready       = ready_q;
    assign bus.fail        = fail_q;
    assign bus.retry_count = retry_q;
    assign bus.lock_lost   = lock_lost_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer.
// Parameters: PLL_RST_CYCLES=4, LOCK_STABLE=8, LOCK_TIMEOUT=32, MAX_RETRIES=2.
// Inputs change 1 time unit after a rising edge, and outputs are sampled at that same point.
// "Pn" is the sample point n edges after rst is released.
module tb_pll_lock_sequencer;
    localparam int RETRY_W = 2;

    logic refclk = 1'b0;
    logic rst    = 1'b1;
    int   tests  = 0;
    int   fails  = 0;

    pll_lock_sequencer_if #(.RETRY_W(RETRY_W)) bus ();

    pll_lock_sequencer #(
        .PLL_RST_CYCLES      (4),
        .LOCK_STABLE_CYCLES  (8),
        .LOCK_TIMEOUT_CYCLES (32),
        .MAX_RETRIES         (2),
        .CNT_W               (6),
        .RETRY_W             (RETRY_W)
    ) dut (
        .refclk (refclk),
        .rst    (rst),
        .bus    (bus.master)
    );

    always #5 refclk = ~refclk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge refclk);
            #1;
        end
    endtask

    // Leaves the bench at P0: rst is just released, and locked is held at lk.
    task automatic do_reset(input logic lk);
        rst         = 1'b1;
        bus.restart = 1'b0;
        bus.locked  = lk;
        tick(2);
        rst = 1'b0;
    endtask

    task automatic test_reset;
        rst         = 1'b1;
        bus.restart = 1'b0;
        bus.locked  = 1'b0;
        tick(2);
        tests++; if (bus.pll_rst !== 1'b1) begin fails++; $display("FAIL reset_pll_rst got %b want 1", bus.pll_rst); end
        tests++; if (bus.sys_rst !== 1'b1) begin fails++; $display("FAIL reset_sys_rst got %b want 1", bus.sys_rst); end
        tests++; if (bus.ready !== 1'b0) begin fails++; $display("FAIL reset_ready got %b want 0", bus.ready); end
        tests++; if (bus.fail !== 1'b0) begin fails++; $display("FAIL reset_fail got %b want 0", bus.fail); end
        tests++; if (bus.retry_count !== 2'd0) begin fails++; $display("FAIL reset_retry got %0d want 0", bus.retry_count); end
        tests++; if (bus.lock_lost !== 1'b0) begin fails++; $display("FAIL reset_lock_lost got %b want 0", bus.lock_lost); end
    endtask

    task automatic test_power_up;
        int hi;
        int first_low;
        int n;
        bit together;
        hi = 0; first_low = -1; n = 0; together = 1'b1;
        do_reset(1'b0);
        for (int i = 0; i < 10; i++) begin
            if (bus.pll_rst === 1'b1) hi++;
            else if (first_low < 0) first_low = i;
            tick(1);
        end
        // At P10 locked rises. locked_sync follows 2 edges later, and ready 9 edges after that.
        bus.locked = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            tick(1);
            if (bus.sys_rst !== ~bus.ready) together = 1'b0;
            if (bus.ready === 1'b1) begin n = i; break; end
        end
        tests++; if (hi != 4) begin fails++; $display("FAIL pwr_pll_rst_width got %0d want 4", hi); end
        tests++; if (first_low != 4) begin fails++; $display("FAIL pwr_pll_rst_release got P%0d want P4", first_low); end
        tests++; if (n != 11) begin fails++; $display("FAIL pwr_ready_latency got %0d want 11", n); end
        tests++; if (!together) begin fails++; $display("FAIL pwr_sys_rst_vs_ready got split want together"); end
        tests++; if (bus.retry_count !== 2'd0) begin fails++; $display("FAIL pwr_retry got %0d want 0", bus.retry_count); end
        tests++; if (bus.fail !== 1'b0) begin fails++; $display("FAIL pwr_fail got %b want 0", bus.fail); end
    endtask

    task automatic test_lock_chatter;
        int n;
        bit pll_quiet;
        n = 0; pll_quiet = 1'b1;
        do_reset(1'b0);
        tick(5);
        bus.locked = 1'b1;
        tick(5);
        bus.locked = 1'b0;
        tick(1);
        bus.locked = 1'b1;
        // STABLE restarts its count at P14, so RUN comes at P22, which is 11 edges after P11.
        for (int i = 1; i <= 40; i++) begin
            tick(1);
            if (bus.pll_rst !== 1'b0) pll_quiet = 1'b0;
            if (bus.ready === 1'b1) begin n = i; break; end
        end
        tests++; if (n != 11) begin fails++; $display("FAIL chatter_ready_latency got %0d want 11", n); end
        tests++; if (!pll_quiet) begin fails++; $display("FAIL chatter_no_timeout got pll_rst pulse want none"); end
        tests++; if (bus.retry_count !== 2'd0) begin fails++; $display("FAIL chatter_retry got %0d want 0", bus.retry_count); end
        tests++; if (bus.sys_rst !== 1'b0) begin fails++; $display("FAIL chatter_sys_rst got %b want 0", bus.sys_rst); end
    endtask

    task automatic test_timeouts;
        logic       pr [0:119];
        logic       sr [0:119];
        logic       fl [0:119];
        logic [1:0] rc [0:119];
        int hi;
        bit sys_held;
        bit pll_held;
        hi = 0; sys_held = 1'b1; pll_held = 1'b1;
        do_reset(1'b0);
        for (int i = 0; i < 120; i++) begin
            pr[i] = bus.pll_rst;
            sr[i] = bus.sys_rst;
            fl[i] = bus.fail;
            rc[i] = bus.retry_count;
            tick(1);
        end
        for (int i = 0; i < 108; i++) if (pr[i] === 1'b1) hi++;
        for (int i = 0; i < 120; i++) if (sr[i] !== 1'b1) sys_held = 1'b0;
        for (int i = 108; i < 120; i++) if (pr[i] !== 1'b1 || fl[i] !== 1'b1) pll_held = 1'b0;
        tests++; if (hi != 12) begin fails++; $display("FAIL tmo_pll_rst_total got %0d want 12", hi); end
        tests++; if (pr[35] !== 1'b0) begin fails++; $display("FAIL tmo_p35_pll_rst got %b want 0", pr[35]); end
        tests++; if (pr[36] !== 1'b1 || pr[39] !== 1'b1 || pr[40] !== 1'b0) begin fails++; $display("FAIL tmo_pulse2 got %b%b%b want 110", pr[36], pr[39], pr[40]); end
        tests++; if (pr[72] !== 1'b1 || pr[75] !== 1'b1 || pr[76] !== 1'b0) begin fails++; $display("FAIL tmo_pulse3 got %b%b%b want 110", pr[72], pr[75], pr[76]); end
        tests++; if (rc[35] !== 2'd0 || rc[36] !== 2'd1) begin fails++; $display("FAIL tmo_retry1 got %0d,%0d want 0,1", rc[35], rc[36]); end
        tests++; if (rc[71] !== 2'd1 || rc[72] !== 2'd2) begin fails++; $display("FAIL tmo_retry2 got %0d,%0d want 1,2", rc[71], rc[72]); end
        tests++; if (fl[107] !== 1'b0 || fl[108] !== 1'b1) begin fails++; $display("FAIL tmo_fail_edge got %b,%b want 0,1", fl[107], fl[108]); end
        tests++; if (!pll_held) begin fails++; $display("FAIL tmo_fail_hold got released want pll_rst=1 fail=1"); end
        tests++; if (!sys_held) begin fails++; $display("FAIL tmo_sys_rst_hold got released want 1"); end
        tests++; if (rc[119] !== 2'd2) begin fails++; $display("FAIL tmo_retry_sat got %0d want 2", rc[119]); end
    endtask

    task automatic test_loss_of_lock;
        do_reset(1'b1);
        tick(13);
        tests++; if (bus.ready !== 1'b1) begin fails++; $display("FAIL lol_initial_ready got %b want 1", bus.ready); end
        bus.locked = 1'b0;
        tick(2);
        tests++; if (bus.ready !== 1'b1) begin fails++; $display("FAIL lol_ready_before_sync got %b want 1", bus.ready); end
        tick(1);
        tests++; if ({bus.ready, bus.sys_rst, bus.pll_rst, bus.lock_lost} !== 4'b0111) begin fails++; $display("FAIL lol_drop got rdy/sys/pll/lost=%b%b%b%b want 0111", bus.ready, bus.sys_rst, bus.pll_rst, bus.lock_lost); end
        tests++; if (bus.retry_count !== 2'd0) begin fails++; $display("FAIL lol_retry got %0d want 0", bus.retry_count); end
        bus.locked = 1'b1;
        tick(12);
        tests++; if (bus.ready !== 1'b0) begin fails++; $display("FAIL lol_relock_early got %b want 0", bus.ready); end
        tick(1);
        tests++; if (bus.ready !== 1'b1 || bus.sys_rst !== 1'b0) begin fails++; $display("FAIL lol_relock got rdy=%b sys=%b want 1,0", bus.ready, bus.sys_rst); end
        tests++; if (bus.lock_lost !== 1'b1) begin fails++; $display("FAIL lol_sticky got %b want 1", bus.lock_lost); end
        tests++; if (bus.retry_count !== 2'd0) begin fails++; $display("FAIL lol_relock_retry got %0d want 0", bus.retry_count); end
    endtask

    task automatic test_restart;
        logic pr [0:13];
        logic rd [0:13];
        int hi;
        hi = 0;
        // Reach RUN, lose lock so that lock_lost is set, relock, then restart at STABLE count 3.
        do_reset(1'b1);
        tick(13);
        bus.locked = 1'b0;
        tick(3);
        tests++; if (bus.lock_lost !== 1'b1) begin fails++; $display("FAIL rst_pre_lock_lost got %b want 1", bus.lock_lost); end
        bus.locked = 1'b1;
        tick(8);
        bus.restart = 1'b1;
        tick(1);
        bus.restart = 1'b0;
        tests++; if ({bus.pll_rst, bus.sys_rst, bus.lock_lost, bus.fail} !== 4'b1100) begin fails++; $display("FAIL rst_stable got pll/sys/lost/fail=%b%b%b%b want 1100", bus.pll_rst, bus.sys_rst, bus.lock_lost, bus.fail); end
        for (int i = 0; i < 14; i++) begin
            pr[i] = bus.pll_rst;
            rd[i] = bus.ready;
            tick(1);
        end
        for (int i = 0; i < 8; i++) if (pr[i] === 1'b1) hi++;
        tests++; if (hi != 4 || pr[3] !== 1'b1 || pr[4] !== 1'b0) begin fails++; $display("FAIL rst_stable_pulse got width %0d want 4", hi); end
        tests++; if (rd[4] !== 1'b0 || rd[12] !== 1'b0 || rd[13] !== 1'b1) begin fails++; $display("FAIL rst_stable_ready got %b%b%b want 001", rd[4], rd[12], rd[13]); end

        // Restart out of FAIL.
        do_reset(1'b0);
        tick(108);
        tests++; if (bus.fail !== 1'b1) begin fails++; $display("FAIL rst_reach_fail got %b want 1", bus.fail); end
        bus.restart = 1'b1;
        tick(1);
        bus.restart = 1'b0;
        tests++; if ({bus.fail, bus.pll_rst, bus.lock_lost} !== 3'b010) begin fails++; $display("FAIL rst_fail_exit got fail/pll/lost=%b%b%b want 010", bus.fail, bus.pll_rst, bus.lock_lost); end
        tests++; if (bus.retry_count !== 2'd0) begin fails++; $display("FAIL rst_fail_retry got %0d want 0", bus.retry_count); end
        hi = 0;
        for (int i = 0; i < 6; i++) begin
            pr[i] = bus.pll_rst;
            if (bus.pll_rst === 1'b1) hi++;
            tick(1);
        end
        tests++; if (hi != 4 || pr[4] !== 1'b0) begin fails++; $display("FAIL rst_fail_pulse got width %0d want 4", hi); end
    endtask

    task automatic test_async_rst;
        do_reset(1'b1);
        tick(13);
        bus.locked = 1'b0;
        tick(3);
        bus.locked = 1'b1;
        tick(13);
        tests++; if (bus.ready !== 1'b1 || bus.lock_lost !== 1'b1) begin fails++; $display("FAIL arst_pre got rdy=%b lost=%b want 1,1", bus.ready, bus.lock_lost); end
        #3;
        rst = 1'b1;
        #1;
        tests++; if ({bus.pll_rst, bus.sys_rst, bus.ready, bus.fail} !== 4'b1100) begin fails++; $display("FAIL arst_outputs got pll/sys/rdy/fail=%b%b%b%b want 1100", bus.pll_rst, bus.sys_rst, bus.ready, bus.fail); end
        tests++; if (bus.lock_lost !== 1'b0 || bus.retry_count !== 2'd0) begin fails++; $display("FAIL arst_status got lost=%b retry=%0d want 0,0", bus.lock_lost, bus.retry_count); end
        tick(1);
        rst = 1'b0;
    endtask

    initial begin
        bus.locked  = 1'b0;
        bus.restart = 1'b0;
        test_reset();
        test_power_up();
        test_lock_chatter();
        test_timeouts();
        test_loss_of_lock();
        test_restart();
        test_async_rst();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got no finish want finish before 200000");
        $fatal(1, "watchdog");
    end

endmodule
